adder_operand_recover: RTL and testbench

- Inverse companion to the team's 17-bit-result ripple adder datapath.
- Takes an adder result `sum_i` (WIDTH+1 bits), one known addend and the carry-in. Recovers the other addend: `operand = sum - addend - cin`.
- Works digit-serially: DIGIT bits per clock, with a registered borrow between digits.
- Used as an on-line checker / operand reconstructor behind the adder. Valid/ready handshake on both sides.

---
 rtl/adder_pkg.sv | 29 ++
 rtl/adder_operand_recover_sub_digit.sv | 24 ++
 rtl/adder_operand_recover.sv | 125 ++++++++++++
 tb/tb_adder_operand_recover.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the adder datapath and its inverse
// (digit-serial operand recovery).
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a one-bit index register.
  function automatic int calc_idx_w(input int width, input int digit);
    int ndig;
    ndig = width / digit;
    if (ndig <= 1) begin
      return 1;
    end else begin
      return $clog2(ndig);
    end
  endfunction

endpackage

// File: rtl/adder_operand_recover_sub_digit.sv
// One DIGIT-bit slice of a - b - bin with borrow-out.
module sub_digit
  import adder_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] diff_o,
  output logic             bout_o
);

  logic [DIGIT:0] full_s;

  // The extra top bit of the widened difference is set exactly when it went negative.
  always_comb begin
    full_s = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT{1'b0}}, bin_i};
  end

  assign diff_o = full_s[DIGIT-1:0];
  assign bout_o = full_s[DIGIT];

endmodule

// File: rtl/adder_operand_recover.sv
// Recovers the unknown addend from an adder result: operand = sum - addend - cin,
// computed DIGIT bits per clock with a registered borrow.
module adder_operand_recover
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_i,
  input  logic [WIDTH-1:0] addend_i,
  input  logic             cin_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operand_o,
  output logic             ovf_o
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int IDXW = calc_idx_w(WIDTH, DIGIT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig_s, b_dig_s, diff_s;
  logic             bout_s;

  // Select the digit currently being worked on.
  always_comb begin
    a_dig_s = sum_q[idx_q*DIGIT +: DIGIT];
    b_dig_s = addend_q[idx_q*DIGIT +: DIGIT];
  end

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a_i    (a_dig_s),
    .b_i    (b_dig_s),
    .bin_i  (borrow_q),
    .diff_o (diff_s),
    .bout_o (bout_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    addend_d  = addend_q;
    operand_d = operand_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d    = sum_i;
          addend_d = addend_i;
          borrow_d = cin_i;
          idx_d    = {IDXW{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        operand_d[idx_q*DIGIT +: DIGIT] = diff_s;
        borrow_d = bout_s;
        if (idx_q == LAST_IDX) begin
          // A carry-out without a final borrow, or a borrow without a carry-out,
          // means no WIDTH-bit operand fits.
          ovf_d   = sum_q[WIDTH] ^ bout_s;
          idx_d   = {IDXW{1'b0}};
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sum_q     <= {(WIDTH+1){1'b0}};
      addend_q  <= {WIDTH{1'b0}};
      operand_q <= {WIDTH{1'b0}};
      idx_q     <= {IDXW{1'b0}};
      borrow_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      addend_q  <= addend_d;
      operand_q <= operand_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign operand_o = operand_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_adder_operand_recover.sv
// Drives three recoverers (DIGIT = 4, 1, 16) in lock-step and checks them
// against an integer model of sum - addend - cin.
module tb_adder_operand_recover;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic          cin;
  logic [W:0]    sum;
  logic [W-1:0]  addend;
  logic [2:0]    in_ready_s;
  logic [2:0]    out_valid_s;
  logic [2:0]    ovf_s;
  logic [W-1:0]  operand_s [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_operand_recover #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[0]),
    .sum_i(sum), .addend_i(addend), .cin_i(cin), .out_valid(out_valid_s[0]),
    .out_ready(out_ready), .operand_o(operand_s[0]), .ovf_o(ovf_s[0]));

  adder_operand_recover #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[1]),
    .sum_i(sum), .addend_i(addend), .cin_i(cin), .out_valid(out_valid_s[1]),
    .out_ready(out_ready), .operand_o(operand_s[1]), .ovf_o(ovf_s[1]));

  adder_operand_recover #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[2]),
    .sum_i(sum), .addend_i(addend), .cin_i(cin), .out_valid(out_valid_s[2]),
    .out_ready(out_ready), .operand_o(operand_s[2]), .ovf_o(ovf_s[2]));

  function automatic int dig_of(input int i);
    case (i)
      0: return 4;
      1: return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int ndig_of(input int i);
    return W / dig_of(i);
  endfunction

  function automatic int model_val(input logic [W:0] s, input logic [W-1:0] a, input logic c);
    return int'(s) - int'(a) - int'(c);
  endfunction

  function automatic logic [W-1:0] model_op(input logic [W:0] s, input logic [W-1:0] a, input logic c);
    int v;
    v = model_val(s, a, c);
    return W'(v);
  endfunction

  function automatic logic model_ovf(input logic [W:0] s, input logic [W-1:0] a, input logic c);
    int v;
    v = model_val(s, a, c);
    return (v < 0) || (v >= (1 << W));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (DIGIT=%0d) observed=0x%0h expected=0x%0h", tag, dig_of(idx), obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) until every instance reaches DONE.
  task automatic start_and_wait(input logic [W:0] s, input logic [W-1:0] a, input logic c,
                                input bit exact_lat);
    int lat [3];
    sum = s; addend = a; cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = -1;
    for (int cyc = 1; cyc <= 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); cyc++) begin
      step();
      for (int i = 0; i < 3; i++)
        if (out_valid_s[i] && lat[i] < 0) lat[i] = cyc;
    end
    for (int i = 0; i < 3; i++) begin
      if (exact_lat) chk("latency", i, 32'(lat[i]), 32'(ndig_of(i)));
      else           chk("done_seen", i, 32'(lat[i] > 0), 32'd1);
      chk("operand", i, 32'(operand_s[i]), 32'(model_op(s, a, c)));
      chk("ovf", i, 32'(ovf_s[i]), 32'(model_ovf(s, a, c)));
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_in_ready", i, 32'(in_ready_s[i]), 32'd1);
      chk("idle_out_valid", i, 32'(out_valid_s[i]), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sum = '0; addend = '0; cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", i, 32'(in_ready_s[i]), 32'd1);
      chk("rst_out_valid", i, 32'(out_valid_s[i]), 32'd0);
      chk("rst_operand", i, 32'(operand_s[i]), 32'd0);
      chk("rst_ovf", i, 32'(ovf_s[i]), 32'd0);
    end

    // Directed vectors, with exact latency.
    start_and_wait(17'h10000, 16'hFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) chk("vec1_op_const", i, 32'(operand_s[i]), 32'h0000);
    release_out();
    start_and_wait(17'h00005, 16'h0003, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) chk("vec2_op_const", i, 32'(operand_s[i]), 32'h0002);
    release_out();
    start_and_wait(17'h1FFFE, 16'hFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) chk("vec3_op_const", i, 32'(operand_s[i]), 32'hFFFE);
    release_out();
    start_and_wait(17'h00000, 16'h0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) chk("vec4_ovf_const", i, 32'(ovf_s[i]), 32'd1);
    release_out();
    start_and_wait(17'h1FFFF, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) chk("vec5_ovf_const", i, 32'(ovf_s[i]), 32'd1);
    release_out();

    // Backpressure: results held, new requests ignored.
    start_and_wait(17'h1A5A5, 16'h1234, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = cyc[0];
      sum = 17'($urandom);
      addend = 16'($urandom);
      cin = 1'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        chk("bp_in_ready", i, 32'(in_ready_s[i]), 32'd0);
        chk("bp_out_valid", i, 32'(out_valid_s[i]), 32'd1);
        chk("bp_operand", i, 32'(operand_s[i]), 32'(model_op(17'h1A5A5, 16'h1234, 1'b1)));
        chk("bp_ovf", i, 32'(ovf_s[i]), 32'(model_ovf(17'h1A5A5, 16'h1234, 1'b1)));
      end
    end
    in_valid = 1'b0;
    release_out();
    step();
    for (int i = 0; i < 3; i++) chk("bp_no_reaccept", i, 32'(out_valid_s[i]), 32'd0);

    // Reset in the middle of a transaction.
    sum = 17'h0ABCD; addend = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_in_ready", i, 32'(in_ready_s[i]), 32'd1);
      chk("abort_out_valid", i, 32'(out_valid_s[i]), 32'd0);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      for (int i = 0; i < 3; i++) chk("abort_no_pulse", i, 32'(out_valid_s[i]), 32'd0);
    end
    start_and_wait(17'h00009, 16'h0004, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) chk("post_abort_op_const", i, 32'(operand_s[i]), 32'h0005);
    release_out();

    // Round trip through an ideal adder: the recovered operand is the other addend.
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 17'(ra) + 17'(rb) + 17'(rc);
      start_and_wait(rs, ra, rc, 1'b0);
      for (int i = 0; i < 3; i++) begin
        chk("rt_operand", i, 32'(operand_s[i]), 32'(rb));
        chk("rt_ovf", i, 32'(ovf_s[i]), 32'd0);
      end
      release_out();
    end

    // Unconstrained sums exercise both overflow directions.
    for (int n = 0; n < 300; n++) begin
      start_and_wait(17'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      release_out();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
